// File: rtl/audio_frame_arbiter_pkg.sv
// Shared types and constants for the AC97 frame arbiter.
package audio_pkg;

  localparam int unsigned FRAME_W = 64;
  localparam logic [FRAME_W-1:0] IDLE_FRAME = '0;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/audio_frame_arbiter_if.sv
// Producer/shifter-side bundle of the frame arbiter.
interface audio_frame_arbiter_if
  import audio_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) ();

  logic [N_REQ-1:0]         req;
  logic [N_REQ*FRAME_W-1:0] req_data;
  logic                     lock0;
  logic [N_REQ-1:0]         gnt;
  logic                     shft_ready;
  logic                     shft_load;
  logic [FRAME_W-1:0]       shft_data;
  logic [15:0]              frames_sent;
  logic                     timeout_err;

  modport master (
    output req, req_data, lock0, shft_ready,
    input  gnt, shft_load, shft_data, frames_sent, timeout_err
  );

  modport slave (
    input  req, req_data, lock0, shft_ready,
    output gnt, shft_load, shft_data, frames_sent, timeout_err
  );

endinterface

// File: rtl/audio_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts just after ptr_i and wraps.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [PTR_W-1:0] win_idx_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] cur;
  logic             found;

  // Walk N_REQ positions from ptr_i+1; first asserted request wins.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cur       = ptr_i;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cur = (cur == PTR_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
      if (!found && req_i[cur]) begin
        found          = 1'b1;
        win_idx_o      = cur;
        win_oh_o[cur]  = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/audio_frame_arbiter.sv
// Grants one frame slot per shifter ready window, round-robin with a
// requester-0 lock, optional idle-frame fill and a busy-drop timeout.
module audio_frame_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned IDLE_FILL    = 1,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  audio_frame_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               load_q, load_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [15:0]        frames_q, frames_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;
  logic [FRAME_W-1:0] win_data;

  // Lock restricts eligibility to requester 0; other requests remain pending.
  always_comb begin
    elig = bus.req;
    if (bus.lock0) elig = bus.req & N_REQ'(1);
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i     (elig),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .valid_o   (win_valid)
  );

  // Select the winning requester's frame from the flattened bus.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) win_data = bus.req_data[FRAME_W*i +: FRAME_W];
    end
  end

  // Next-state and registered-output decisions.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    load_d   = 1'b0;
    data_d   = data_q;
    frames_d = frames_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.shft_ready) begin
          if (win_valid) begin
            gnt_d    = win_oh;
            load_d   = 1'b1;
            data_d   = win_data;
            frames_d = frames_q + 16'd1;
            ptr_d    = win_idx;
            state_d  = WAIT_BUSY;
          end else if (IDLE_FILL != 0) begin
            load_d  = 1'b1;
            data_d  = IDLE_FRAME;
            state_d = WAIT_BUSY;
          end
        end
      end
      WAIT_BUSY: begin
        if (!bus.shft_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(N_REQ - 1);
      gnt_q    <= '0;
      load_q   <= 1'b0;
      data_q   <= '0;
      frames_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      load_q   <= load_d;
      data_q   <= data_d;
      frames_q <= frames_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.shft_load   = load_q;
  assign bus.shft_data   = data_q;
  assign bus.frames_sent = frames_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_audio_frame_arbiter.sv
// Directed bench for audio_frame_arbiter: lock, round-robin, idle fill,
// busy timeout, reset during wait and frames_sent wrap.
module tb_audio_frame_arbiter;
  import audio_pkg::*;

  localparam logic [63:0] F0 = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] F1 = 64'hB1B2B3B4B5B6B7B8;
  localparam logic [63:0] F2 = 64'hC2C3C4C5C6C7C8C9;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  audio_frame_arbiter_if #(.N_REQ(3)) bus ();
  audio_frame_arbiter_if #(.N_REQ(3)) bus_nf ();

  assign bus_nf.req        = bus.req;
  assign bus_nf.req_data   = bus.req_data;
  assign bus_nf.lock0      = bus.lock0;
  assign bus_nf.shft_ready = bus.shft_ready;

  audio_frame_arbiter #(.N_REQ(3), .IDLE_FILL(1), .BUSY_TIMEOUT(255)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  audio_frame_arbiter #(.N_REQ(3), .IDLE_FILL(0), .BUSY_TIMEOUT(255)) dut_nf (
    .clk (clk), .rst (rst), .bus (bus_nf.slave)
  );

  // Ready high for one decision edge; returns at the following negedge.
  task automatic open_window();
    bus.shft_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Shifter drops ready for one cycle.
  task automatic close_window();
    bus.shft_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.lock0 = 1'b1; bus.shft_ready = 1'b0;
    bus.req_data = {F2, F1, F0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", bus.gnt); end
    checks++; if (bus.shft_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", bus.shft_load); end
    checks++; if (bus.shft_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.shft_data); end
    checks++; if (bus.frames_sent !== 16'h0) begin errors++; $display("FAIL reset_frames got %h exp 0", bus.frames_sent); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    bus.lock0 = 1'b1; bus.req = 3'b111;
    for (int k = 1; k <= 3; k++) begin
      open_window();
      checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL lock_gnt k=%0d got %b exp 001", k, bus.gnt); end
      checks++; if (bus.shft_load !== 1'b1) begin errors++; $display("FAIL lock_load k=%0d got %b exp 1", k, bus.shft_load); end
      checks++; if (bus.shft_data !== F0) begin errors++; $display("FAIL lock_data k=%0d got %h exp %h", k, bus.shft_data, F0); end
      checks++; if (bus.frames_sent !== 16'(k)) begin errors++; $display("FAIL lock_frames k=%0d got %0d exp %0d", k, bus.frames_sent, k); end
      close_window();
      checks++; if ({bus.gnt, bus.shft_load} !== 4'b0000) begin errors++; $display("FAIL lock_pulse_width k=%0d got %b exp 0000", k, {bus.gnt, bus.shft_load}); end
    end
  endtask

  task automatic test_round_robin();
    int unsigned ord [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0]  eg;
    logic [63:0] ed;
    do_reset();
    bus.lock0 = 1'b0; bus.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      eg = 3'b001 << ord[k];
      ed = (ord[k] == 0) ? F0 : (ord[k] == 1) ? F1 : F2;
      open_window();
      checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL rr_gnt k=%0d got %b exp %b", k, bus.gnt, eg); end
      checks++; if (bus.shft_data !== ed) begin errors++; $display("FAIL rr_data k=%0d got %h exp %h", k, bus.shft_data, ed); end
      checks++; if (bus.frames_sent !== 16'(k + 1)) begin errors++; $display("FAIL rr_frames k=%0d got %0d exp %0d", k, bus.frames_sent, k + 1); end
      close_window();
    end
  endtask

  task automatic test_idle_fill();
    bus.req = 3'b000;
    open_window();
    checks++; if (bus.shft_load !== 1'b1) begin errors++; $display("FAIL idle_load got %b exp 1", bus.shft_load); end
    checks++; if (bus.shft_data !== IDLE_FRAME) begin errors++; $display("FAIL idle_data got %h exp 0", bus.shft_data); end
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL idle_gnt got %b exp 000", bus.gnt); end
    checks++; if (bus.frames_sent !== 16'd6) begin errors++; $display("FAIL idle_frames got %0d exp 6", bus.frames_sent); end
    checks++; if (bus_nf.shft_load !== 1'b0) begin errors++; $display("FAIL nofill_load got %b exp 0", bus_nf.shft_load); end
    close_window();
    // Locked, only ineligible requests pending: idle frame, requests kept.
    bus.lock0 = 1'b1; bus.req = 3'b110;
    open_window();
    checks++; if ({bus.gnt, bus.shft_load} !== 4'b0001) begin errors++; $display("FAIL locked_idle got %b exp 0001", {bus.gnt, bus.shft_load}); end
    close_window();
    bus.lock0 = 1'b0;
    open_window();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL pending_gnt got %b exp 010", bus.gnt); end
    checks++; if (bus.frames_sent !== 16'd7) begin errors++; $display("FAIL pending_frames got %0d exp 7", bus.frames_sent); end
    close_window();
  endtask

  task automatic test_timeout();
    bus.lock0 = 1'b0; bus.req = 3'b001;
    bus.shft_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL to_first_gnt got %b exp 001", bus.gnt); end
    repeat (254) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_err got %b exp 0", bus.timeout_err); end
    checks++; if (bus.shft_load !== 1'b0) begin errors++; $display("FAIL to_wait_load got %b exp 0", bus.shft_load); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", bus.timeout_err); end
    @(posedge clk); @(negedge clk);
    checks++; if ({bus.gnt, bus.shft_load} !== 4'b0011) begin errors++; $display("FAIL to_next_frame got %b exp 0011", {bus.gnt, bus.shft_load}); end
    checks++; if (bus.frames_sent !== 16'd9) begin errors++; $display("FAIL to_frames got %0d exp 9", bus.frames_sent); end
    close_window();
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", bus.timeout_err); end
  endtask

  task automatic test_reset_in_wait();
    bus.lock0 = 1'b0; bus.req = 3'b111;
    open_window();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL rw_pre_gnt got %b exp 010", bus.gnt); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({bus.gnt, bus.shft_load} !== 4'b0000) begin errors++; $display("FAIL rw_pulses got %b exp 0000", {bus.gnt, bus.shft_load}); end
    checks++; if (bus.shft_data !== 64'h0) begin errors++; $display("FAIL rw_data got %h exp 0", bus.shft_data); end
    checks++; if (bus.frames_sent !== 16'h0) begin errors++; $display("FAIL rw_frames got %0d exp 0", bus.frames_sent); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rw_err got %b exp 0", bus.timeout_err); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({bus.gnt, bus.shft_load} !== 4'b0011) begin errors++; $display("FAIL rw_first_gnt got %b exp 0011", {bus.gnt, bus.shft_load}); end
    checks++; if (bus.shft_data !== F0) begin errors++; $display("FAIL rw_first_data got %h exp %h", bus.shft_data, F0); end
    close_window();
  endtask

  task automatic test_wrap();
    force dut.frames_q = 16'hFFFE;
    #1;
    release dut.frames_q;
    bus.lock0 = 1'b0; bus.req = 3'b111;
    open_window();
    checks++; if (bus.frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", bus.frames_sent); end
    close_window();
    open_window();
    checks++; if (bus.frames_sent !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", bus.frames_sent); end
    checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL wrap_gnt got %b exp 100", bus.gnt); end
    close_window();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_round_robin();
    test_idle_fill();
    test_timeout();
    test_reset_in_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
